// File: rtl/ctrl_types_pkg.sv
// Shared types for the cache controller stage.
// Operation codes and controller FSM states.
package ctrl_types_pkg;

  typedef enum logic [2:0] {
    OP_NOOP   = 3'd0,
    OP_READ   = 3'd1,
    OP_UPSERT = 3'd2,
    OP_DELETE = 3'd3
  } operation_e;

  typedef enum logic [1:0] {
    CTRL_ST_IDLE,
    CTRL_ST_LOOKUP,
    CTRL_ST_EXECUTE,
    CTRL_ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/cache_store.sv
// Fully-associative key/value array with parallel match,
// lowest-free search, one write port and one invalidate port.
module cache_store
  import ctrl_types_pkg::*;
#(
  parameter int KEY_W = 61,
  parameter int VAL_W = 128,
  parameter int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic             any_free,
  output logic [IDX_W-1:0] free_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [VAL_W-1:0] rd_value,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [VAL_W-1:0] wr_value,
  input  logic             inv,
  input  logic [IDX_W-1:0] inv_idx,
  output logic [IDX_W:0]   occupancy
);

  logic [N-1:0]     valid;
  logic [KEY_W-1:0] keys [N];
  logic [VAL_W-1:0] vals [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (we)  valid[wr_idx]  <= 1'b1;
      if (inv) valid[inv_idx] <= 1'b0;
    end
  end

  // Contents need no reset: valid bits gate them.
  always_ff @(posedge clk) begin
    if (we) begin
      keys[wr_idx] <= wr_key;
      vals[wr_idx] <= wr_value;
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (valid[i] && keys[i] == key) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < N; i++) begin
      occupancy = occupancy
                + {{IDX_W{1'b0}}, valid[i]};
    end
  end

  assign rd_value = vals[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Key/value cache controller: IDLE -> LOOKUP -> EXECUTE -> DONE,
// with round-robin eviction when the store is full.
module cache_ctrl
  import ctrl_types_pkg::*;
#(
  parameter int ARCHITECTURE = 64,
  parameter int NUM_ENTRIES  = 8,
  localparam int KEY_WIDTH   = ARCHITECTURE - 3,
  localparam int VALUE_WIDTH = 2 * ARCHITECTURE,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [2:0]             operation_in,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  output logic                   ready_out,
  output logic                   done_out,
  output logic                   op_succ_out,
  output logic [VALUE_WIDTH-1:0] result_out,
  output logic [IDX_W:0]         occupancy_out
);

  ctrl_state_e state, state_n;

  logic [2:0]             op_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] val_q;

  logic             hit_q, any_free_q;
  logic [IDX_W-1:0] hit_idx_q, free_idx_q;
  logic [IDX_W-1:0] victim_q;

  logic                   succ_q;
  logic [VALUE_WIDTH-1:0] result_q;

  logic             hit, any_free;
  logic [IDX_W-1:0] hit_idx, free_idx;
  logic [VALUE_WIDTH-1:0] rd_value;

  logic             we, inv, evict;
  logic [IDX_W-1:0] wr_idx;
  logic             exec_succ;
  logic [VALUE_WIDTH-1:0] exec_result;

  cache_store #(
    .KEY_W (KEY_WIDTH),
    .VAL_W (VALUE_WIDTH),
    .N     (NUM_ENTRIES)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .key       (key_q),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .any_free  (any_free),
    .free_idx  (free_idx),
    .rd_idx    (hit_idx_q),
    .rd_value  (rd_value),
    .we        (we),
    .wr_idx    (wr_idx),
    .wr_key    (key_q),
    .wr_value  (val_q),
    .inv       (inv),
    .inv_idx   (hit_idx_q),
    .occupancy (occupancy_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= CTRL_ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ready_out   = 1'b0;
    done_out    = 1'b0;
    op_succ_out = 1'b0;
    result_out  = '0;
    unique case (state)
      CTRL_ST_IDLE: begin
        ready_out = 1'b1;
        if (valid_in) state_n = CTRL_ST_LOOKUP;
      end
      CTRL_ST_LOOKUP:  state_n = CTRL_ST_EXECUTE;
      CTRL_ST_EXECUTE: state_n = CTRL_ST_DONE;
      CTRL_ST_DONE: begin
        done_out    = 1'b1;
        op_succ_out = succ_q;
        result_out  = result_q;
        state_n     = CTRL_ST_IDLE;
      end
      default: state_n = CTRL_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CTRL_ST_IDLE && valid_in) begin
      op_q  <= operation_in;
      key_q <= key_in;
      val_q <= value_in;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CTRL_ST_LOOKUP) begin
      hit_q      <= hit;
      hit_idx_q  <= hit_idx;
      any_free_q <= any_free;
      free_idx_q <= free_idx;
    end
  end

  // Store side effects exist only during EXECUTE.
  always_comb begin
    we          = 1'b0;
    inv         = 1'b0;
    evict       = 1'b0;
    wr_idx      = free_idx_q;
    exec_succ   = 1'b0;
    exec_result = '0;
    if (state == CTRL_ST_EXECUTE) begin
      unique case (1'b1)
        (op_q == OP_READ): begin
          exec_succ = hit_q;
          if (hit_q) exec_result = rd_value;
        end
        (op_q == OP_UPSERT): begin
          we        = 1'b1;
          exec_succ = 1'b1;
          if (hit_q) begin
            wr_idx = hit_idx_q;
          end else if (!any_free_q) begin
            wr_idx = victim_q;
            evict  = 1'b1;
          end
        end
        (op_q == OP_DELETE): begin
          inv       = hit_q;
          exec_succ = hit_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      victim_q <= '0;
      succ_q   <= 1'b0;
      result_q <= '0;
    end else if (state == CTRL_ST_EXECUTE) begin
      succ_q   <= exec_succ;
      result_q <= exec_result;
      if (evict) victim_q <= victim_q + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a scoreboard of
// expected completions checked on each done_out pulse.
module tb_cache_ctrl;
  import ctrl_types_pkg::*;

  localparam int ARCH = 64;
  localparam int N    = 8;
  localparam int KW   = ARCH - 3;
  localparam int VW   = 2 * ARCH;
  localparam int IW   = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [2:0]    operation_in = '0;
  logic [KW-1:0] key_in = '0;
  logic [VW-1:0] value_in = '0;
  logic          ready_out;
  logic          done_out;
  logic          op_succ_out;
  logic [VW-1:0] result_out;
  logic [IW:0]   occupancy_out;

  cache_ctrl #(
    .ARCHITECTURE (ARCH),
    .NUM_ENTRIES  (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .operation_in  (operation_in),
    .key_in        (key_in),
    .value_in      (value_in),
    .ready_out     (ready_out),
    .done_out      (done_out),
    .op_succ_out   (op_succ_out),
    .result_out    (result_out),
    .occupancy_out (occupancy_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          succ;
    logic [VW-1:0] res;
    int            acc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    exp_t e;
    if (done_out === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        assert (done_out === 1'b0) else begin
          errors++;
          $error("FAIL unexpected_done observed=%b expected=0",
                 done_out);
        end
      end else begin
        e = q.pop_front();
        checks += 3;
        assert (op_succ_out === e.succ) else begin
          errors++;
          $error("FAIL succ observed=%b expected=%b",
                 op_succ_out, e.succ);
        end
        assert (result_out === e.res) else begin
          errors++;
          $error("FAIL result observed=%h expected=%h",
                 result_out, e.res);
        end
        assert ((cyc - e.acc) == 3) else begin
          errors++;
          $error("FAIL latency observed=%0d expected=3",
                 cyc - e.acc);
        end
      end
    end else begin
      checks++;
      assert (op_succ_out === 1'b0 && result_out === '0)
      else begin
        errors++;
        $error("FAIL idle_outputs observed=%b/%h expected=0/0",
               op_succ_out, result_out);
      end
    end
  end

  task automatic issue(input logic [2:0] op,
                       input int key,
                       input int val,
                       input logic esucc,
                       input int eres);
    int guard;
    @(negedge clk);
    guard = 0;
    while (ready_out !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    assert (ready_out === 1'b1) else begin
      errors++;
      $error("FAIL ready_timeout observed=%b expected=1",
             ready_out);
    end
    valid_in     = 1'b1;
    operation_in = op;
    key_in       = KW'(key);
    value_in     = VW'(val);
    q.push_back('{esucc, VW'(eres), cyc});
    @(negedge clk);
    valid_in = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL done_timeout observed=%0d expected=0",
             q.size());
      q.delete();
    end
  endtask

  task automatic check_occ(input int exp);
    checks++;
    assert (occupancy_out === (IW+1)'(exp)) else begin
      errors++;
      $error("FAIL occupancy observed=%0d expected=%0d",
             occupancy_out, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill8();
    for (int k = 1; k <= 8; k++)
      issue(OP_UPSERT, k, 256 + k, 1'b1, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    do_reset();
    checks++;
    assert (ready_out === 1'b1 && done_out === 1'b0)
    else begin
      errors++;
      $error("FAIL reset_hs observed=%b%b expected=10",
             ready_out, done_out);
    end
    check_occ(0);

    issue(OP_UPSERT, 5, 'hAA, 1'b1, 0);
    issue(OP_READ, 5, 0, 1'b1, 'hAA);
    check_occ(1);

    do_reset();
    issue(OP_READ, 9, 0, 1'b0, 0);
    issue(OP_DELETE, 9, 0, 1'b0, 0);
    check_occ(0);

    issue(OP_UPSERT, 5, 'hAA, 1'b1, 0);
    issue(OP_UPSERT, 5, 'hBB, 1'b1, 0);
    check_occ(1);
    issue(OP_READ, 5, 0, 1'b1, 'hBB);

    // eviction and victim wrap
    do_reset();
    fill8();
    check_occ(8);
    issue(OP_UPSERT, 9, 'h109, 1'b1, 0);
    check_occ(8);
    issue(OP_READ, 1, 0, 1'b0, 0);
    issue(OP_READ, 9, 0, 1'b1, 'h109);
    issue(OP_READ, 2, 0, 1'b1, 'h102);
    for (int k = 10; k <= 17; k++)
      issue(OP_UPSERT, k, 256 + k, 1'b1, 0);
    check_occ(8);
    issue(OP_READ, 9, 0, 1'b0, 0);
    issue(OP_READ, 17, 0, 1'b1, 'h111);
    issue(OP_READ, 8, 0, 1'b0, 0);
    issue(OP_READ, 10, 0, 1'b1, 'h10A);

    // delete then refill free slot
    do_reset();
    fill8();
    issue(OP_DELETE, 3, 0, 1'b1, 0);
    check_occ(7);
    issue(OP_READ, 3, 0, 1'b0, 0);
    issue(OP_UPSERT, 20, 'h14AB, 1'b1, 0);
    check_occ(8);
    issue(OP_READ, 1, 0, 1'b1, 'h101);
    issue(OP_READ, 4, 0, 1'b1, 'h104);
    issue(OP_READ, 8, 0, 1'b1, 'h108);
    issue(OP_READ, 20, 0, 1'b1, 'h14AB);
    issue(OP_UPSERT, 21, 'h15, 1'b1, 0);
    issue(OP_READ, 1, 0, 1'b0, 0);
    issue(OP_READ, 2, 0, 1'b1, 'h102);
    issue(OP_READ, 20, 0, 1'b1, 'h14AB);

    // illegal opcode
    issue(3'd6, 20, 'hDEAD, 1'b0, 0);
    check_occ(8);
    issue(OP_READ, 20, 0, 1'b1, 'h14AB);

    // valid held high: one accept per four cycles
    @(negedge clk);
    valid_in     = 1'b1;
    operation_in = OP_READ;
    key_in       = KW'(20);
    value_in     = '0;
    k0 = cyc;
    for (int i = 0; i < 4; i++)
      q.push_back('{1'b1, VW'('h14AB), k0 + 4 * i});
    repeat (15) @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL stream_count observed=%0d expected=0",
             q.size());
      q.delete();
    end

    // reset while an UPSERT is in EXECUTE
    @(negedge clk);
    valid_in     = 1'b1;
    operation_in = OP_UPSERT;
    key_in       = KW'('h77);
    value_in     = VW'('h55);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_occ(0);
    checks++;
    assert (ready_out === 1'b1) else begin
      errors++;
      $error("FAIL ready_after_abort observed=%b expected=1",
             ready_out);
    end
    issue(OP_READ, 'h77, 0, 1'b0, 0);
    check_occ(0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
